// File: rtl/chipset_wait_state_controller_if.sv
// CPU-side bus bundle: address/command strobes in, RDY back to the CPU.
// Master drives the bus cycle, slave (the wait-state controller) returns RDY.
interface chipset_wait_state_controller_if #(
    parameter int ADDR_W = 20
);
    logic              cpu_clock_posedge;
    logic              ALE;
    logic [ADDR_W-1:0] ADDRESS;
    logic              IO_OR_M;
    logic              RD_N;
    logic              WR_N;
    logic              INTA_N;
    logic              RDY;

    modport master (
        output cpu_clock_posedge, ALE, ADDRESS, IO_OR_M, RD_N, WR_N, INTA_N,
        input  RDY
    );

    modport slave (
        input  cpu_clock_posedge, ALE, ADDRESS, IO_OR_M, RD_N, WR_N, INTA_N,
        output RDY
    );
endinterface

// File: rtl/chipset_wait_state_controller.sv
// Decodes the ALE-latched address against N_CH windows and stretches RDY by wait states plus ext ready.
// All outputs registered; state only advances on qualified (cpu_clock_posedge) clocks, watchdog bounds RDY low.
module chipset_wait_state_controller #(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 20,
    parameter int WAIT_W    = 4,
    parameter int TMO_W     = 8,
    parameter int TIMEOUT   = 200,
    parameter int INTA_WAIT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    chipset_wait_state_controller_if.slave bus,
    input  logic [N_CH*ADDR_W-1:0]   ch_base,
    input  logic [N_CH*ADDR_W-1:0]   ch_mask,
    input  logic [N_CH-1:0]          ch_is_io,
    input  logic [N_CH-1:0]          ch_enable,
    input  logic [N_CH*WAIT_W-1:0]   ch_wait,
    input  logic [N_CH-1:0]          ch_ext_ready,
    output logic                     busy,
    output logic [2:0]               active_ch,
    output logic                     timeout,
    output logic [2:0]               timeout_ch
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCHED,
        S_WAIT,
        S_EXTW,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               hit_q, hit_d;
    logic [2:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               inta_q, inta_d;
    logic [WAIT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               timeout_q, timeout_d;
    logic [2:0]         timeout_ch_q, timeout_ch_d;

    logic               hit_c;
    logic [2:0]         idx_c;
    logic [WAIT_W-1:0]  wait_c;
    logic               ext_sel;
    logic               cmd;
    logic               inta_now;
    logic               ready_ok;
    logic [WAIT_W-1:0]  eff_wait;

    assign cmd      = ~bus.RD_N | ~bus.WR_N | ~bus.INTA_N;
    assign inta_now = ~bus.INTA_N;
    assign ready_ok = inta_q | ext_sel;

    // Scan high to low so the lowest matching window overrides.
    always_comb begin
        hit_c  = 1'b0;
        idx_c  = 3'd0;
        wait_c = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_enable[i] && (ch_is_io[i] == bus.IO_OR_M) &&
                (((bus.ADDRESS ^ ch_base[i*ADDR_W +: ADDR_W]) & ch_mask[i*ADDR_W +: ADDR_W]) == '0)) begin
                hit_c  = 1'b1;
                idx_c  = 3'(i);
                wait_c = ch_wait[i*WAIT_W +: WAIT_W];
            end
        end
    end

    always_comb begin
        ext_sel = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx_q == 3'(i)) begin
                ext_sel = ch_ext_ready[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rdy_d        = rdy_q;
        hit_d        = hit_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        inta_d       = inta_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        timeout_d    = 1'b0;
        timeout_ch_d = timeout_ch_q;
        eff_wait     = inta_now ? WAIT_W'(INTA_WAIT) : wait_q;

        if (bus.cpu_clock_posedge) begin
            tmo_d = rdy_q ? '0 : tmo_q + TMO_W'(1);
            case (state_q)
                S_WAIT, S_EXTW: begin
                    if (!cmd) begin
                        state_d = S_IDLE;
                        rdy_d   = 1'b1;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d      = S_DONE;
                        rdy_d        = 1'b1;
                        tmo_d        = '0;
                        timeout_d    = 1'b1;
                        timeout_ch_d = idx_q;
                    end else if (state_q == S_WAIT && cnt_q != WAIT_W'(1)) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else if (ready_ok) begin
                        // Last wait state samples ext ready directly, so wait=N costs exactly N edges.
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                        tmo_d   = '0;
                    end else begin
                        state_d = S_EXTW;
                    end
                end
                default: begin
                    if (bus.ALE) begin
                        state_d = S_LATCHED;
                        hit_d   = hit_c;
                        idx_d   = idx_c;
                        wait_d  = wait_c;
                        inta_d  = 1'b0;
                    end else if (state_q == S_LATCHED && cmd) begin
                        inta_d = inta_now;
                        if (!inta_now && !hit_q) begin
                            state_d = S_DONE;
                        end else if (eff_wait == '0) begin
                            if (inta_now || ext_sel) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_EXTW;
                                rdy_d   = 1'b0;
                            end
                        end else begin
                            state_d = S_WAIT;
                            rdy_d   = 1'b0;
                            cnt_d   = eff_wait;
                        end
                    end else if (state_q == S_DONE && !cmd) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end

        busy_d = (state_d == S_WAIT) || (state_d == S_EXTW);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rdy_q        <= 1'b1;
            busy_q       <= 1'b0;
            hit_q        <= 1'b0;
            idx_q        <= 3'd0;
            wait_q       <= '0;
            inta_q       <= 1'b0;
            cnt_q        <= '0;
            tmo_q        <= '0;
            timeout_q    <= 1'b0;
            timeout_ch_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= rdy_d;
            busy_q       <= busy_d;
            hit_q        <= hit_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            inta_q       <= inta_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            timeout_q    <= timeout_d;
            timeout_ch_q <= timeout_ch_d;
        end
    end

    assign bus.RDY    = rdy_q;
    assign busy       = busy_q;
    assign active_ch  = idx_q;
    assign timeout    = timeout_q;
    assign timeout_ch = timeout_ch_q;

endmodule

// File: tb/tb_chipset_wait_state_controller.sv
// Directed bus cycles against the wait-state controller; every qualified edge is followed by one unqualified clock.
module tb_chipset_wait_state_controller;
    localparam int N_CH      = 4;
    localparam int ADDR_W    = 20;
    localparam int WAIT_W    = 4;
    localparam int TMO_W     = 8;
    localparam int TIMEOUT   = 200;
    localparam int INTA_WAIT = 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    chipset_wait_state_controller_if #(.ADDR_W(ADDR_W)) bus ();

    logic [N_CH*ADDR_W-1:0] ch_base, ch_mask;
    logic [N_CH-1:0]        ch_is_io, ch_enable, ch_ext_ready;
    logic [N_CH*WAIT_W-1:0] ch_wait;
    logic                   busy, timeout;
    logic [2:0]             active_ch, timeout_ch;

    chipset_wait_state_controller #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .TMO_W(TMO_W),
        .TIMEOUT(TIMEOUT), .INTA_WAIT(INTA_WAIT)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .ch_base(ch_base), .ch_mask(ch_mask), .ch_is_io(ch_is_io), .ch_enable(ch_enable),
        .ch_wait(ch_wait), .ch_ext_ready(ch_ext_ready),
        .busy(busy), .active_ch(active_ch), .timeout(timeout), .timeout_ch(timeout_ch)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   edge_k;
    int   ready_after;
    int   ext_win;
    logic to_q, to_after, busy0;
    int   low;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_ready();
        ch_ext_ready          = '1;
        ch_ext_ready[ext_win] = (edge_k >= ready_after);
    endtask

    task automatic qedge();
        bus.cpu_clock_posedge = 1'b1;
        @(posedge clock); #1;
        to_q = timeout;
        bus.cpu_clock_posedge = 1'b0;
        @(posedge clock); #1;
        to_after = timeout;
    endtask

    // kind: 0 read, 1 write, 2 interrupt acknowledge
    task automatic start_cycle(input logic [ADDR_W-1:0] addr, input logic io, input int kind);
        bus.ALE = 1'b1; bus.ADDRESS = addr; bus.IO_OR_M = io;
        qedge();
        bus.ALE = 1'b0;
        bus.RD_N = (kind != 0); bus.WR_N = (kind != 1); bus.INTA_N = (kind != 2);
        edge_k = 0;
        set_ready();
        qedge();
        busy0 = busy;
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (bus.RDY == 1'b0 && n < 400) begin
            edge_k++;
            set_ready();
            qedge();
            n++;
        end
    endtask

    task automatic finish_cycle();
        bus.RD_N = 1'b1; bus.WR_N = 1'b1; bus.INTA_N = 1'b1;
        qedge();
    endtask

    initial begin
        reset = 1'b1;
        bus.cpu_clock_posedge = 1'b0; bus.ALE = 1'b0; bus.ADDRESS = '0; bus.IO_OR_M = 1'b0;
        bus.RD_N = 1'b1; bus.WR_N = 1'b1; bus.INTA_N = 1'b1;
        ch_base  = {20'h40000, 20'hB0000, 20'h000C0, 20'hB8000};
        ch_mask  = {20'hF0000, 20'hF0000, 20'h003F8, 20'hF8000};
        ch_is_io = 4'b0010;
        ch_enable = 4'b1111;
        ch_wait  = {4'd2, 4'd4, 4'd0, 4'd3};
        ext_win = 0; ready_after = 0; edge_k = 0;
        set_ready();
        #23;
        check_eq("reset_rdy", bus.RDY, 1);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_active_ch", active_ch, 0);
        check_eq("reset_timeout", timeout, 0);
        check_eq("reset_timeout_ch", timeout_ch, 0);
        reset = 1'b0;
        #4;

        // Memory read in win0, 3 wait states, ext ready already high.
        ext_win = 0; ready_after = 0;
        start_cycle(20'hB8123, 1'b0, 0);
        check_eq("w0_busy", busy0, 1);
        count_low(low);
        check_eq("w0_low_edges", low, 3);
        check_eq("w0_active_ch", active_ch, 0);
        finish_cycle();

        // I/O write in win1, no wait states, ext ready low for 5 edges.
        ext_win = 1; ready_after = 5;
        start_cycle(20'h000C0, 1'b1, 1);
        count_low(low);
        check_eq("io_low_edges", low, 5);
        check_eq("io_active_ch", active_ch, 1);
        finish_cycle();
        check_eq("io_idle_busy", busy, 0);

        // Overlap win0/win2: lowest index with 1 wait state.
        ch_wait[3:0] = 4'd1;
        ext_win = 0; ready_after = 0;
        start_cycle(20'hB8010, 1'b0, 0);
        count_low(low);
        check_eq("ovl_low_edges", low, 1);
        check_eq("ovl_active_ch", active_ch, 0);
        finish_cycle();
        ch_wait[3:0] = 4'd3;

        // Window 2 on its own.
        ext_win = 2; ready_after = 0;
        start_cycle(20'hB0010, 1'b0, 0);
        count_low(low);
        check_eq("w2_low_edges", low, 4);
        check_eq("w2_active_ch", active_ch, 2);
        finish_cycle();

        // INTA with no window hit.
        ext_win = 0; ready_after = 1000;
        start_cycle(20'h12345, 1'b0, 2);
        count_low(low);
        check_eq("inta_low_edges", low, 1);
        check_eq("inta_active_ch", active_ch, 0);
        finish_cycle();

        // Unmapped memory read: RDY never drops.
        ext_win = 0; ready_after = 0;
        start_cycle(20'h12345, 1'b0, 0);
        check_eq("unmapped_busy", busy0, 0);
        count_low(low);
        check_eq("unmapped_low_edges", low, 0);
        finish_cycle();

        // Command dropped while stretched.
        ext_win = 1; ready_after = 1000;
        start_cycle(20'h000C4, 1'b1, 0);
        qedge();
        finish_cycle();
        check_eq("abort_rdy", bus.RDY, 1);
        check_eq("abort_timeout", to_q, 0);
        check_eq("abort_busy", busy, 0);

        // Reset while waiting for ext ready, then a normal cycle.
        ext_win = 1; ready_after = 1000;
        start_cycle(20'h000C0, 1'b1, 0);
        qedge(); qedge();
        check_eq("pre_reset_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_rdy", bus.RDY, 1);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_active_ch", active_ch, 0);
        bus.RD_N = 1'b1;
        #3 reset = 1'b0;
        @(posedge clock); #1;
        ext_win = 0; ready_after = 0;
        start_cycle(20'hB8000, 1'b0, 0);
        count_low(low);
        check_eq("postrst_low_edges", low, 3);
        finish_cycle();

        // Watchdog: win3, 2 wait states, ext ready stuck low.
        ext_win = 3; ready_after = 1000;
        start_cycle(20'h4ABCD, 1'b0, 0);
        count_low(low);
        check_eq("tmo_low_edges", low, TIMEOUT);
        check_eq("tmo_pulse", to_q, 1);
        check_eq("tmo_pulse_end", to_after, 0);
        check_eq("tmo_ch", timeout_ch, 3);
        check_eq("tmo_busy", busy, 0);
        finish_cycle();
        check_eq("tmo_ch_hold", timeout_ch, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
